// File: rtl/message_handler_v2_if.sv
// message_handler_v2_if: NoC-in, controller-in and packetizer-out buses of message_handler_v2.
// Latency: none (wires only).
// Backpressure: packetizer_busy stalls the handler; intf_busy stalls the controller.
interface message_handler_v2_if #(
  parameter int MSG_BITS     = 4,
  parameter int ADDRESS_BITS = 32,
  parameter int CACHE_WIDTH  = 128,
  parameter int ID_BITS      = 3
);
  // Incoming NoC message (from depacketizer)
  logic [MSG_BITS-1:0]     noc_msg_in;
  logic [ADDRESS_BITS-1:0] noc_address_in;
  logic [CACHE_WIDTH-1:0]  noc_data_in;
  logic [ID_BITS-1:0]      noc_src_id;
  // Outgoing NoC message (to packetizer)
  logic                    packetizer_busy;
  logic [MSG_BITS-1:0]     noc_msg_out;
  logic [ADDRESS_BITS-1:0] noc_address_out;
  logic [CACHE_WIDTH-1:0]  noc_data_out;
  logic [ID_BITS-1:0]      noc_dest_id;
  // Controller message
  logic [MSG_BITS-1:0]     ctrl_msg_in;
  logic [ADDRESS_BITS-1:0] ctrl_address_in;
  logic [CACHE_WIDTH-1:0]  ctrl_data_in;
  logic [ID_BITS-1:0]      ctrl_dest_id;
  logic                    intf_busy;

  // Handler side
  modport slave (
    input  noc_msg_in, noc_address_in, noc_data_in, noc_src_id,
    input  packetizer_busy,
    input  ctrl_msg_in, ctrl_address_in, ctrl_data_in, ctrl_dest_id,
    output noc_msg_out, noc_address_out, noc_data_out, noc_dest_id,
    output intf_busy
  );

  // Environment side (controller, packetizer, depacketizer)
  modport master (
    output noc_msg_in, noc_address_in, noc_data_in, noc_src_id,
    output packetizer_busy,
    output ctrl_msg_in, ctrl_address_in, ctrl_data_in, ctrl_dest_id,
    input  noc_msg_out, noc_address_out, noc_data_out, noc_dest_id,
    input  intf_busy
  );
endinterface

// File: rtl/message_handler_v2.sv
// message_handler_v2: classifies NoC messages into request/response buffers, Nacks overflowing
// requests, and arbitrates Nacks (priority) and controller messages onto the packetizer.
// Latency: 1 cycle into buffers/FIFOs, +1 cycle to the registered packetizer output.
// Backpressure: packetizer_busy holds the output stage; intf_busy (output FIFO full) holds the controller.
// Optional: define MH_NACK_STATS_EN for the saturating consumed-Nack counter on o_nack_count.

// mh2_fifo: generic power-of-two FIFO with combinational head and occupancy flags.
// Latency: push visible at head one cycle after the edge.
// Backpressure: push on full is dropped and flagged on o_overflow; pop on empty is ignored.
module mh2_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_BITS = 1
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_overflow
);
  localparam int                    DEPTH    = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0]   CNT_FULL = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]   CNT_ONE  = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

  logic [W-1:0]          r_mem [DEPTH];
  logic [DEPTH_BITS-1:0] r_wr_ptr;
  logic [DEPTH_BITS-1:0] r_rd_ptr;
  logic [DEPTH_BITS:0]   r_count;
  logic                  w_push_eff;
  logic                  w_pop_eff;

  // Full is judged before the edge, so a same-cycle pop never makes room for a push.
  assign o_full     = (r_count == CNT_FULL);
  assign o_empty    = (r_count == '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_overflow = i_push && o_full;
  assign w_push_eff = i_push && !o_full;
  assign w_pop_eff  = i_pop && !o_empty;

  // Storage is only read when occupied, so it carries no reset.
  always_ff @(posedge i_clock) begin
    if (w_push_eff) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers wrap at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_eff) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_eff)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_eff, w_pop_eff})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module message_handler_v2 #(
  parameter int CACHE_OFFSET_BITS   = 2,
  parameter int DATA_WIDTH          = 32,
  parameter int ADDRESS_BITS        = 32,
  parameter int MSG_BITS            = 4,
  parameter int ID_BITS             = 3,
  parameter int REQ_BUF_DEPTH_BITS  = 2,
  parameter int RESP_BUF_DEPTH_BITS = 2,
  parameter int OUT_BUF_DEPTH_BITS  = 1,
  parameter int NACK_BUF_DEPTH_BITS = 1,
  parameter logic [MSG_BITS-1:0]        NO_MSG       = '0,
  parameter logic [MSG_BITS-1:0]        NACK_MSG     = MSG_BITS'(4'hC),
  parameter logic [(1<<MSG_BITS)-1:0]   REQ_MSG_MASK = '0,
  localparam int CACHE_WIDTH = DATA_WIDTH << CACHE_OFFSET_BITS,
  localparam int BUF_WIDTH   = ID_BITS + MSG_BITS + ADDRESS_BITS + CACHE_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  message_handler_v2_if.slave   bus,
  input  logic                  i_reqbuf_read,
  input  logic                  i_respbuf_read,
  output logic                  o_reqbuf_empty,
  output logic                  o_reqbuf_full,
  output logic                  o_reqbuf_valid,
  output logic [BUF_WIDTH-1:0]  o_reqbuf_data,
  output logic                  o_respbuf_empty,
  output logic                  o_respbuf_full,
  output logic                  o_respbuf_valid,
  output logic [BUF_WIDTH-1:0]  o_respbuf_data,
  output logic                  o_err_overflow,
  output logic [15:0]           o_nack_count
);
  // Buffer entry, MSB first: {id, msg, addr, data}
  typedef struct packed {
    logic [ID_BITS-1:0]      id;
    logic [MSG_BITS-1:0]     msg;
    logic [ADDRESS_BITS-1:0] addr;
    logic [CACHE_WIDTH-1:0]  data;
  } buf_t;

  // Rejected request: who to tell and which address
  typedef struct packed {
    logic [ID_BITS-1:0]      id;
    logic [ADDRESS_BITS-1:0] addr;
  } nack_t;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  logic  w_noc_vld, w_noc_is_req;
  buf_t  w_noc_ent, w_ctrl_ent;
  nack_t w_nack_ent;
  logic  w_req_push, w_resp_push, w_nack_push, w_out_push;
  logic  w_req_pop, w_resp_pop, w_nack_pop, w_out_pop;
  buf_t  w_req_head, w_resp_head, w_out_head;
  nack_t w_nack_head;
  logic  w_req_empty, w_req_full, w_resp_empty, w_resp_full;
  logic  w_nack_empty, w_nack_full, w_out_empty, w_out_full;
  logic  w_req_ovf, w_resp_ovf, w_nack_ovf, w_out_ovf;
  logic  w_consume;

  logic  r_reqbuf_valid, r_respbuf_valid, r_err;
  buf_t  r_reqbuf_data, r_respbuf_data;
  state_t r_state, w_state_nxt;
  buf_t  r_out, w_out_nxt;

  assign w_noc_vld    = (bus.noc_msg_in != NO_MSG);
  assign w_noc_is_req = REQ_MSG_MASK[bus.noc_msg_in];
  assign w_noc_ent    = '{bus.noc_src_id, bus.noc_msg_in, bus.noc_address_in, bus.noc_data_in};
  assign w_ctrl_ent   = '{bus.ctrl_dest_id, bus.ctrl_msg_in, bus.ctrl_address_in, bus.ctrl_data_in};
  assign w_nack_ent   = '{bus.noc_src_id, bus.noc_address_in};

  // A request meeting a full buffer turns into a Nack instead of a push.
  assign w_req_push  = w_noc_vld && w_noc_is_req && !w_req_full;
  assign w_nack_push = w_noc_vld && w_noc_is_req && w_req_full;
  assign w_resp_push = w_noc_vld && !w_noc_is_req;
  assign w_out_push  = (bus.ctrl_msg_in != NO_MSG) && !w_out_full;
  assign w_req_pop   = i_reqbuf_read && !w_req_empty;
  assign w_resp_pop  = i_respbuf_read && !w_resp_empty;

  mh2_fifo #(.W(BUF_WIDTH), .DEPTH_BITS(REQ_BUF_DEPTH_BITS)) u_req_fifo (
    .i_clock(i_clock), .i_reset(i_reset), .i_push(w_req_push), .i_push_dat(w_noc_ent),
    .i_pop(w_req_pop), .o_head_dat(w_req_head), .o_empty(w_req_empty), .o_full(w_req_full),
    .o_overflow(w_req_ovf));

  mh2_fifo #(.W(BUF_WIDTH), .DEPTH_BITS(RESP_BUF_DEPTH_BITS)) u_resp_fifo (
    .i_clock(i_clock), .i_reset(i_reset), .i_push(w_resp_push), .i_push_dat(w_noc_ent),
    .i_pop(w_resp_pop), .o_head_dat(w_resp_head), .o_empty(w_resp_empty), .o_full(w_resp_full),
    .o_overflow(w_resp_ovf));

  mh2_fifo #(.W(ID_BITS + ADDRESS_BITS), .DEPTH_BITS(NACK_BUF_DEPTH_BITS)) u_nack_fifo (
    .i_clock(i_clock), .i_reset(i_reset), .i_push(w_nack_push), .i_push_dat(w_nack_ent),
    .i_pop(w_nack_pop), .o_head_dat(w_nack_head), .o_empty(w_nack_empty), .o_full(w_nack_full),
    .o_overflow(w_nack_ovf));

  mh2_fifo #(.W(BUF_WIDTH), .DEPTH_BITS(OUT_BUF_DEPTH_BITS)) u_out_fifo (
    .i_clock(i_clock), .i_reset(i_reset), .i_push(w_out_push), .i_push_dat(w_ctrl_ent),
    .i_pop(w_out_pop), .o_head_dat(w_out_head), .o_empty(w_out_empty), .o_full(w_out_full),
    .o_overflow(w_out_ovf));

  assign bus.intf_busy   = w_out_full;
  assign o_reqbuf_empty  = w_req_empty;
  assign o_reqbuf_full   = w_req_full;
  assign o_respbuf_empty = w_resp_empty;
  assign o_respbuf_full  = w_resp_full;
  assign o_reqbuf_valid  = r_reqbuf_valid;
  assign o_respbuf_valid = r_respbuf_valid;
  assign o_reqbuf_data   = r_reqbuf_data;
  assign o_respbuf_data  = r_respbuf_data;
  assign o_err_overflow  = r_err;

  // Popped entries: one-cycle valid pulse, data held until the next successful pop.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_reqbuf_valid  <= 1'b0;
      r_respbuf_valid <= 1'b0;
      r_reqbuf_data   <= '0;
      r_respbuf_data  <= '0;
    end else begin
      r_reqbuf_valid  <= w_req_pop;
      r_respbuf_valid <= w_resp_pop;
      if (w_req_pop)  r_reqbuf_data  <= w_req_head;
      if (w_resp_pop) r_respbuf_data <= w_resp_head;
    end
  end

  // Sticky overflow: any dropped response, Nack or controller message.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_err <= 1'b0;
    else          r_err <= r_err | w_resp_ovf | w_nack_ovf | w_out_ovf | w_req_ovf;
  end

  // Output stage state and registered packetizer message.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
      r_out   <= '{'0, NO_MSG, '0, '0};
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Output stage: hold while busy, reload on consumption with Nacks ahead of controller traffic.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_nack_pop  = 1'b0;
    w_out_pop   = 1'b0;
    w_consume   = 1'b0;
    if (r_state == ST_HOLD && !bus.packetizer_busy) begin
      w_consume   = 1'b1;
      w_state_nxt = ST_IDLE;
      w_out_nxt   = '{'0, NO_MSG, '0, '0};
    end
    if (r_state == ST_IDLE || w_consume) begin
      if (!w_nack_empty) begin
        w_nack_pop  = 1'b1;
        w_state_nxt = ST_HOLD;
        w_out_nxt   = '{w_nack_head.id, NACK_MSG, w_nack_head.addr, '0};
      end else if (!w_out_empty) begin
        w_out_pop   = 1'b1;
        w_state_nxt = ST_HOLD;
        w_out_nxt   = w_out_head;
      end
    end
  end

  assign bus.noc_msg_out     = r_out.msg;
  assign bus.noc_address_out = r_out.addr;
  assign bus.noc_data_out    = r_out.data;
  assign bus.noc_dest_id     = r_out.id;

`ifdef MH_NACK_STATS_EN
  logic        r_is_nack;
  logic [15:0] r_nack_count;

  // Remember whether the presented message is a Nack, and count Nacks the packetizer takes.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_is_nack    <= 1'b0;
      r_nack_count <= 16'd0;
    end else begin
      if (w_nack_pop)     r_is_nack <= 1'b1;
      else if (w_out_pop) r_is_nack <= 1'b0;
      if (w_consume && r_is_nack && r_nack_count != 16'hFFFF)
        r_nack_count <= r_nack_count + 16'd1;
    end
  end

  assign o_nack_count = r_nack_count;
`else
  assign o_nack_count = 16'd0;
`endif
endmodule

// File: tb/tb_message_handler_v2.sv
// tb_message_handler_v2: directed test-plan steps plus a random phase, checked against a
// queue-based transaction model of the handler.
module tb_message_handler_v2;
  localparam int BW     = 167;
  localparam int REQ_D  = 4;
  localparam int RESP_D = 4;
  localparam int OUT_D  = 2;
  localparam int NACK_D = 2;

  typedef struct packed {
    logic [2:0]   id;
    logic [3:0]   msg;
    logic [31:0]  addr;
    logic [127:0] data;
  } msg_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic reqbuf_read  = 1'b0;
  logic respbuf_read = 1'b0;
  logic reqbuf_empty, reqbuf_full, reqbuf_valid, respbuf_empty, respbuf_full, respbuf_valid;
  logic [BW-1:0] reqbuf_data, respbuf_data;
  logic err_overflow;
  logic [15:0] nack_count;

  always #5 clk = ~clk;

  message_handler_v2_if #(.MSG_BITS(4), .ADDRESS_BITS(32), .CACHE_WIDTH(128), .ID_BITS(3)) bus ();

  message_handler_v2 #(.REQ_MSG_MASK(16'h0046)) dut (
    .i_clock(clk), .i_reset(rst_n), .bus(bus),
    .i_reqbuf_read(reqbuf_read), .i_respbuf_read(respbuf_read),
    .o_reqbuf_empty(reqbuf_empty), .o_reqbuf_full(reqbuf_full), .o_reqbuf_valid(reqbuf_valid),
    .o_reqbuf_data(reqbuf_data),
    .o_respbuf_empty(respbuf_empty), .o_respbuf_full(respbuf_full), .o_respbuf_valid(respbuf_valid),
    .o_respbuf_data(respbuf_data),
    .o_err_overflow(err_overflow), .o_nack_count(nack_count));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit [15:0] mask_v = 16'h0046;
  msg_t q_req[$], q_resp[$], q_out[$], q_nack[$];
  bit   m_hold, m_cur_nack, m_req_vld, m_resp_vld, m_err;
  msg_t m_cur, m_req_dat, m_resp_dat;
  int   m_nacks;
  bit   last_ctrl_acc;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q_req.delete(); q_resp.delete(); q_out.delete(); q_nack.delete();
    m_hold = 0; m_cur_nack = 0; m_req_vld = 0; m_resp_vld = 0; m_err = 0;
    m_cur = '0; m_req_dat = '0; m_resp_dat = '0; m_nacks = 0; last_ctrl_acc = 0;
  endtask

  task automatic check_all();
    msg_t exp_out;
    logic [15:0] exp_cnt;
    exp_out = m_hold ? m_cur : '0;
`ifdef MH_NACK_STATS_EN
    exp_cnt = (m_nacks > 65535) ? 16'hFFFF : 16'(m_nacks);
`else
    exp_cnt = 16'd0;
`endif
    check("noc_out", 256'({bus.noc_dest_id, bus.noc_msg_out, bus.noc_address_out, bus.noc_data_out}),
          256'(exp_out));
    check("intf_busy", 256'(bus.intf_busy), 256'(q_out.size() == OUT_D));
    check("reqbuf_empty", 256'(reqbuf_empty), 256'(q_req.size() == 0));
    check("reqbuf_full", 256'(reqbuf_full), 256'(q_req.size() == REQ_D));
    check("respbuf_empty", 256'(respbuf_empty), 256'(q_resp.size() == 0));
    check("respbuf_full", 256'(respbuf_full), 256'(q_resp.size() == RESP_D));
    check("reqbuf_valid", 256'(reqbuf_valid), 256'(m_req_vld));
    check("reqbuf_data", 256'(reqbuf_data), 256'(m_req_dat));
    check("respbuf_valid", 256'(respbuf_valid), 256'(m_resp_vld));
    check("respbuf_data", 256'(respbuf_data), 256'(m_resp_dat));
    check("err_overflow", 256'(err_overflow), 256'(m_err));
    check("nack_count", 256'(nack_count), 256'(exp_cnt));
  endtask

  // Apply one clock edge to the model using the inputs currently driven, then compare.
  task automatic tick();
    msg_t nin, cin, nk;
    bit busy_pre, req_full_pre, resp_full_pre, nack_full_pre, consume;
    nin = '{bus.noc_src_id, bus.noc_msg_in, bus.noc_address_in, bus.noc_data_in};
    cin = '{bus.ctrl_dest_id, bus.ctrl_msg_in, bus.ctrl_address_in, bus.ctrl_data_in};
    busy_pre      = (q_out.size() == OUT_D);
    req_full_pre  = (q_req.size() == REQ_D);
    resp_full_pre = (q_resp.size() == RESP_D);
    nack_full_pre = (q_nack.size() == NACK_D);
    consume = m_hold && !bus.packetizer_busy;
    if (consume && m_cur_nack) m_nacks++;
    if (!m_hold || consume) begin
      if (q_nack.size() > 0) begin
        m_cur = q_nack.pop_front(); m_cur_nack = 1; m_hold = 1;
      end else if (q_out.size() > 0) begin
        m_cur = q_out.pop_front(); m_cur_nack = 0; m_hold = 1;
      end else begin
        m_hold = 0; m_cur_nack = 0;
      end
    end
    m_req_vld = reqbuf_read && (q_req.size() > 0);
    if (m_req_vld) m_req_dat = q_req.pop_front();
    m_resp_vld = respbuf_read && (q_resp.size() > 0);
    if (m_resp_vld) m_resp_dat = q_resp.pop_front();
    if (nin.msg != 4'd0) begin
      if (mask_v[nin.msg]) begin
        if (!req_full_pre) q_req.push_back(nin);
        else if (nack_full_pre) m_err = 1;
        else begin
          nk = '{nin.id, 4'hC, nin.addr, 128'd0};
          q_nack.push_back(nk);
        end
      end else begin
        if (resp_full_pre) m_err = 1;
        else q_resp.push_back(nin);
      end
    end
    last_ctrl_acc = (cin.msg != 4'd0) && !busy_pre;
    if (last_ctrl_acc) q_out.push_back(cin);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_noc(input logic [3:0] m, input logic [31:0] a, input logic [2:0] s);
    bus.noc_msg_in = m; bus.noc_address_in = a; bus.noc_src_id = s;
    bus.noc_data_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic set_ctrl(input logic [3:0] m, input logic [31:0] a, input logic [2:0] d);
    bus.ctrl_msg_in = m; bus.ctrl_address_in = a; bus.ctrl_dest_id = d;
    bus.ctrl_data_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    logic [3:0] codes [6];
    logic [3:0] cm [3];
    msg_t rd;
    int idx;

    set_noc(4'd0, 32'd0, 3'd0);
    set_ctrl(4'd0, 32'd0, 3'd0);
    bus.packetizer_busy = 1'b0;

    // Reset state
    #1;
    reset_model();
    check_all();
    #1 rst_n = 1'b1;

    // Fill: requests 1,1,6,2 interleaved with responses 3,5
    codes[0] = 4'd1; codes[1] = 4'd3; codes[2] = 4'd1;
    codes[3] = 4'd6; codes[4] = 4'd5; codes[5] = 4'd2;
    for (int i = 0; i < 6; i++) begin
      set_noc(codes[i], $urandom, 3'($urandom_range(0, 7)));
      tick();
    end
    check("plan_reqbuf_full", 256'(reqbuf_full), 256'(1'b1));

    // Rejected request becomes a Nack two edges later
    set_noc(4'd6, 32'h20002000, 3'd5);
    tick();
    set_noc(4'd0, 32'd0, 3'd0);
    tick();
    check("plan_nack_msg", 256'(bus.noc_msg_out), 256'(4'hC));
    check("plan_nack_addr", 256'(bus.noc_address_out), 256'(32'h20002000));
    check("plan_nack_dest", 256'(bus.noc_dest_id), 256'(3'd5));
    check("plan_nack_data", 256'(bus.noc_data_out), 256'(128'd0));
    tick();

    // Nack and controller message in the same cycle: Nack wins
    set_noc(4'd1, $urandom, 3'd2);
    set_ctrl(4'd7, 32'h50005000, 3'd7);
    tick();
    set_noc(4'd0, 32'd0, 3'd0);
    set_ctrl(4'd0, 32'd0, 3'd0);
    tick();
    check("plan_prio_first", 256'(bus.noc_msg_out), 256'(4'hC));
    tick();
    check("plan_prio_second", 256'(bus.noc_msg_out), 256'(4'd7));
    check("plan_prio_addr", 256'(bus.noc_address_out), 256'(32'h50005000));
    check("plan_prio_dest", 256'(bus.noc_dest_id), 256'(3'd7));
    tick();

    // Packetizer busy for 5 cycles while 3 controller messages arrive
    cm[0] = 4'd8; cm[1] = 4'd9; cm[2] = 4'd10;
    bus.packetizer_busy = 1'b1;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) set_ctrl(cm[idx], $urandom, 3'($urandom_range(0, 7)));
      else set_ctrl(4'd0, 32'd0, 3'd0);
      tick();
      if (last_ctrl_acc) idx++;
      if (c == 2) check("plan_busy_full", 256'(bus.intf_busy), 256'(1'b1));
    end
    check("plan_held_while_busy", 256'(bus.noc_msg_out), 256'(4'd8));
    set_ctrl(4'd0, 32'd0, 3'd0);
    bus.packetizer_busy = 1'b0;
    tick();
    check("plan_order_b", 256'(bus.noc_msg_out), 256'(4'd9));
    tick();
    check("plan_order_c", 256'(bus.noc_msg_out), 256'(4'd10));
    tick();

    // Pop the response buffer twice, then once more on empty
    respbuf_read = 1'b1;
    tick();
    rd = respbuf_data;
    check("plan_resp_pop1_vld", 256'(respbuf_valid), 256'(1'b1));
    check("plan_resp_pop1_msg", 256'(rd.msg), 256'(4'd3));
    tick();
    rd = respbuf_data;
    check("plan_resp_pop2_msg", 256'(rd.msg), 256'(4'd5));
    check("plan_resp_empty", 256'(respbuf_empty), 256'(1'b1));
    tick();
    check("plan_resp_pop3_vld", 256'(respbuf_valid), 256'(1'b0));
    respbuf_read = 1'b0;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 0) set_noc(4'd0, 32'd0, 3'd0);
      else set_noc(4'($urandom_range(1, 15)), $urandom, 3'($urandom_range(0, 7)));
      if (!(bus.ctrl_msg_in != 4'd0 && !last_ctrl_acc)) begin
        if ($urandom_range(0, 1) == 0) set_ctrl(4'd0, 32'd0, 3'd0);
        else set_ctrl(4'($urandom_range(1, 15)), $urandom, 3'($urandom_range(0, 7)));
      end
      bus.packetizer_busy = ($urandom_range(0, 9) < 4);
      reqbuf_read  = ($urandom_range(0, 9) < 3);
      respbuf_read = ($urandom_range(0, 9) < 3);
      tick();
    end

    // Reset in the middle of a held transfer
    set_noc(4'd0, 32'd0, 3'd0);
    reqbuf_read = 1'b0;
    respbuf_read = 1'b0;
    bus.packetizer_busy = 1'b1;
    set_ctrl(4'd7, $urandom, 3'd3);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    reset_model();
    check_all();
    check("reset_msg_out", 256'(bus.noc_msg_out), 256'(4'd0));
    #1 rst_n = 1'b1;
    set_ctrl(4'd0, 32'd0, 3'd0);
    bus.packetizer_busy = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
